ibex_fetch_req_ctrl: RTL and testbench

- Request-side controller of the instruction prefetch path.
- Drives the instruction memory bus (req/gnt/rvalid) and forwards responses, together with the clear/branch address, into the fetch FIFO input port (valid/addr/rdata/err/clear).
- Tracks up to NUM_REQS outstanding bus transactions, throttles requests from FIFO occupancy, and discards responses belonging to fetches made before a branch.

---
 rtl/ibex_fetch_req_ctrl.sv | 85 ++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// ibex_fetch_req_ctrl: instruction bus request side of the prefetch path.
// Issues OBI fetches, tracks outstanding slots and drops responses made stale by a branch.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o
);
  logic                valid_req_q, branch_pend_q, branch_pend_d;
  logic [29:0]         fetch_addr_q, fetch_addr_d, pend_addr_q, pend_addr_d, sel_addr, req_addr;
  logic [NUM_REQS-1:0] outst_q, outst_s, outst_d, discard_q, discard_s, discard_d;
  logic                new_req, gnt, rvalid, new_discard;
  assign new_req      = req_i & (~&fifo_busy_i | branch_i) & ~outst_q[NUM_REQS-1];
  assign instr_req_o  = valid_req_q | new_req;
  assign gnt          = instr_req_o & instr_gnt_i;
  assign rvalid       = instr_rvalid_i & outst_q[0];
  assign sel_addr     = branch_i ? addr_i[31:2] : branch_pend_q ? pend_addr_q : fetch_addr_q;
  // a held request keeps its address in fetch_addr_q so it stays stable until granted
  assign req_addr     = valid_req_q ? fetch_addr_q : sel_addr;
  assign instr_addr_o = {req_addr, 2'b00};
  assign new_discard  = valid_req_q & (branch_pend_q | branch_i);
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = rvalid & ~discard_q[0] & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | outst_q[0];
  always_comb begin
    outst_s       = rvalid ? outst_q >> 1 : outst_q;
    discard_s     = (rvalid ? discard_q >> 1 : discard_q) | (branch_i ? outst_s : '0);
    outst_d       = gnt ? {outst_s[NUM_REQS-2:0], 1'b1} : outst_s;
    discard_d     = discard_s | ((gnt & new_discard) ? (outst_d & ~outst_s) : '0);
    fetch_addr_d  = gnt ? req_addr + 30'd1 :
                    (~valid_req_q & (instr_req_o | branch_i)) ? sel_addr : fetch_addr_q;
    branch_pend_d = (branch_i & valid_req_q) |
                    (branch_pend_q & ~(branch_i | (instr_req_o & ~valid_req_q)));
    pend_addr_d   = (branch_i & valid_req_q) ? addr_i[31:2] : pend_addr_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_req_q   <= 1'b0;
      branch_pend_q <= 1'b0;
      outst_q       <= '0;
      discard_q     <= '0;
    end else begin
      valid_req_q   <= instr_req_o & ~instr_gnt_i;
      branch_pend_q <= branch_pend_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
    end
  end
  if (ResetAll) begin : g_addr_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fetch_addr_q <= '0;
        pend_addr_q  <= '0;
      end else begin
        fetch_addr_q <= fetch_addr_d;
        pend_addr_q  <= pend_addr_d;
      end
    end
  end else begin : g_addr
    always_ff @(posedge clk_i) begin
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
    end
  end
endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// tb_ibex_fetch_req_ctrl: directed plus random stimulus against a transaction-queue model.
module tb_ibex_fetch_req_ctrl;
  localparam int N = 2;
  logic          clk_i = 0, rst_ni = 0, req_i = 0, branch_i = 0;
  logic [31:0]   addr_i = 0, instr_rdata_i = 0;
  logic [N-1:0]  fifo_busy_i = 0;
  logic          instr_gnt_i = 0, instr_rvalid_i = 0, instr_err_i = 0;
  logic          fifo_clear_o, fifo_valid_o, fifo_err_o, instr_req_o, busy_o;
  logic [31:0]   fifo_addr_o, fifo_rdata_o, instr_addr_o;
  int            total = 0, bad = 0;
  always #5 clk_i = ~clk_i;
  ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o), .fifo_valid_o(fifo_valid_o),
    .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .busy_o(busy_o)
  );
  // model: queue of outstanding transactions (1 = stale), one held request, next fetch address
  bit            q[$];
  bit            held = 0, held_stale = 0, held_known = 0, nxt_known = 0;
  logic [31:0]   held_addr = 0, nxt = 0;
  bit            m_r, m_g, m_b, m_st, m_ak, e_v;
  logic [31:0]   m_a, m_t;
  function automatic bit m_req();
    return held || (req_i && (!(&fifo_busy_i) || branch_i) && q.size() < N);
  endfunction
  function automatic logic [31:0] m_addr();
    return held ? held_addr : branch_i ? (addr_i & 32'hFFFF_FFFC) : nxt;
  endfunction
  function automatic bit m_addr_known();
    return held ? held_known : (branch_i || nxt_known);
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      q.delete();
      held = 0; held_stale = 0; held_known = 0; nxt_known = 0;
    end else begin
      m_r = m_req(); m_a = m_addr(); m_ak = m_addr_known(); m_b = branch_i;
      m_t = addr_i & 32'hFFFF_FFFC;
      m_g = m_r && instr_gnt_i;
      e_v = instr_rvalid_i && q.size() > 0 && !m_b && (q.size() > 0 ? !q[0] : 1'b0);
      chk("req", instr_req_o, m_r);
      if (m_r && m_ak) chk("addr", instr_addr_o, m_a);
      chk("clear", fifo_clear_o, m_b);
      chk("faddr", fifo_addr_o, addr_i);
      chk("fvalid", fifo_valid_o, e_v);
      if (e_v) begin
        chk("rdata", fifo_rdata_o, instr_rdata_i);
        chk("err", fifo_err_o, instr_err_i);
      end
      chk("busy", busy_o, m_r || q.size() > 0);
      if (instr_rvalid_i && q.size() > 0) q.delete(0);
      if (m_b) foreach (q[i]) q[i] = 1'b1;
      if (m_g) begin
        m_st = held && (held_stale || m_b);
        q.push_back(m_st);
        if (!m_st) begin nxt = m_a + 32'd4; nxt_known = m_ak; end
        else if (m_b) begin nxt = m_t; nxt_known = 1; end
        held = 0;
      end else if (m_r && !held) begin
        held = 1; held_addr = m_a; held_known = m_ak; held_stale = 0;
      end else if (m_b) begin
        nxt = m_t; nxt_known = 1;
        if (held) held_stale = 1;
      end
    end
  end
  task automatic drive(bit r, bit b, logic [31:0] a, logic [N-1:0] fb, bit g, bit rv, logic [31:0] rd);
    @(posedge clk_i); #1;
    req_i = r; branch_i = b; addr_i = a; fifo_busy_i = fb;
    instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = 0;
    @(negedge clk_i);
  endtask
  initial begin
    @(negedge clk_i);
    chk("rst_req", instr_req_o, 0);
    chk("rst_valid", fifo_valid_o, 0);
    chk("rst_clear", fifo_clear_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk_i); #1 rst_ni = 1;
    drive(1, 1, 32'h100, 0, 1, 0, 0);
    chk("t1_addr", instr_addr_o, 32'h100);
    chk("t1_clear", fifo_clear_o, 1);
    drive(1, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("t1_addr2", instr_addr_o, 32'h104);
    chk("t1_fvalid", fifo_valid_o, 1);
    chk("t1_rdata", fifo_rdata_o, 32'hDEADBEEF);
    chk("t1_noclear", fifo_clear_o, 0);
    drive(1, 1, 32'h200, 0, 0, 0, 0);
    chk("t2_hold1", instr_addr_o, 32'h104);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t2_hold2", instr_addr_o, 32'h104);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("t2_hold3", instr_addr_o, 32'h104);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("t2_tgt", instr_addr_o, 32'h200);
    drive(1, 0, 0, 0, 1, 1, 32'h1234);
    chk("t2_full", instr_req_o, 0);
    chk("t2_drop", fifo_valid_o, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h11112222);
    chk("t2_fwd", fifo_valid_o, 1);
    chk("t2_next", instr_addr_o, 32'h204);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("t2_keep", instr_req_o, 1);
    chk("t2_keepa", instr_addr_o, 32'h204);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t2_idle", busy_o, 0);
    drive(1, 1, 32'h300, 0, 1, 0, 0);
    chk("t3_a0", instr_addr_o, 32'h300);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("t3_a1", instr_addr_o, 32'h304);
    drive(1, 1, 32'h402, 0, 1, 0, 0);
    chk("t3_faddr", fifo_addr_o, 32'h402);
    chk("t3_full", instr_req_o, 0);
    drive(1, 0, 0, 0, 1, 1, 32'h300);
    chk("t3_drop0", fifo_valid_o, 0);
    drive(1, 0, 0, 0, 1, 1, 32'h304);
    chk("t3_drop1", fifo_valid_o, 0);
    chk("t3_a400", instr_addr_o, 32'h400);
    drive(0, 0, 0, 0, 0, 1, 32'hAAAA0400);
    chk("t3_fwd", fifo_valid_o, 1);
    chk("t3_rdata", fifo_rdata_o, 32'hAAAA0400);
    drive(1, 0, 0, 2'b11, 1, 0, 0);
    chk("t4_busy", instr_req_o, 0);
    drive(1, 1, 32'h500, 2'b11, 1, 0, 0);
    chk("t4_br", instr_req_o, 1);
    chk("t4_bra", instr_addr_o, 32'h500);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("t4_a504", instr_addr_o, 32'h504);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("t4_full", instr_req_o, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    chk("t4_full2", instr_req_o, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    chk("t4_free", instr_req_o, 1);
    chk("t4_a508", instr_addr_o, 32'h508);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 32'hFFFF_FFFC, 0, 1, 0, 0);
    chk("t5_top", instr_addr_o, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("t5_wrap", instr_addr_o, 32'h0);
    @(posedge clk_i); #1;
    req_i = 0; instr_gnt_i = 0; rst_ni = 0;
    #2;
    chk("t6_rbusy", busy_o, 0);
    chk("t6_rreq", instr_req_o, 0);
    @(posedge clk_i); #1 rst_ni = 1;
    drive(0, 0, 0, 0, 0, 1, 32'h55);
    chk("t6_stray0", fifo_valid_o, 0);
    chk("t6_busy0", busy_o, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h66);
    chk("t6_stray1", fifo_valid_o, 0);
    chk("t6_busy1", busy_o, 0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      req_i          = $urandom_range(0, 7) != 0;
      branch_i       = (c == 0) || ($urandom_range(0, 7) == 0);
      addr_i         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFA : ($urandom & 32'hFFFF_FFFE);
      fifo_busy_i    = 2'($urandom_range(0, 3));
      instr_gnt_i    = $urandom_range(0, 2) != 0;
      instr_rvalid_i = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      instr_rdata_i  = $urandom;
      instr_err_i    = 1'($urandom_range(0, 1));
      rst_ni         = $urandom_range(0, 499) != 0;
    end
    @(posedge clk_i); #1 rst_ni = 1;
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
